// File: rtl/tiles_pkg.sv
// Shared types and defaults for the tile lane scheduler and the tile lanes.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
package tiles_pkg;

    localparam int NUM_TILES = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } sched_state_t;

    // Feedback taps for x^8+x^6+x^5+x^4+1 on a left-shifting register (bits 7,5,4,3).
    localparam logic [7:0] LFSR_TAPS = 8'hB8;

    localparam int BASE_SPEED_DEF = 64;
    localparam int SPEED_STEP_DEF = 8;
    localparam int MAX_SPEED_DEF  = 256;

    // Add with saturation at lim; the sum is widened so it cannot wrap before the compare.
    function automatic logic [31:0] sat_add(input logic [31:0] a,
                                            input logic [31:0] b,
                                            input logic [31:0] lim);
        logic [32:0] s;
        s = {1'b0, a} + {1'b0, b};
        return (s > {1'b0, lim}) ? lim : s[31:0];
    endfunction

endpackage

// File: rtl/tile_lfsr8.sv
// 8-bit Fibonacci LFSR, advances one step per enabled cycle; never reaches zero from a non-zero seed.
// Latency: new value visible the cycle after en.
// Backpressure: none; en simply holds the current value when low.
module tile_lfsr8
    import tiles_pkg::*;
#(
    parameter logic [7:0] SEED = 8'hA5
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    output logic [7:0] lfsr
);

    logic [7:0] lfsr_q;
    logic [7:0] lfsr_d;

    // Shift left, feeding the XOR of the tapped bits into bit 0.
    always_comb begin
        lfsr_d = lfsr_q;
        if (en) begin
            lfsr_d = {lfsr_q[6:0], ^(lfsr_q & LFSR_TAPS)};
        end
    end

    // State register, restarts from the seed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lfsr_q <= SEED;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign lfsr = lfsr_q;

endmodule

// File: rtl/tile_spawn_scheduler.sv
// Schedules tile spawns across the lanes (round-robin, gap-timed), hands out LFSR seeds, ramps scroll speed.
// Latency: spawn pulse/seed/levelDone combinational in the deciding cycle; activeVector/levelSpeed one cycle later.
// Backpressure: with every lane busy a due spawn stays pending until a lane frees; no other stalls.
module tile_spawn_scheduler
    import tiles_pkg::*;
#(
    parameter int         SPAWN_GAP_TENTHS = 15,
    parameter int         BASE_SPEED       = BASE_SPEED_DEF,
    parameter int         SPEED_STEP       = SPEED_STEP_DEF,
    parameter int         MAX_SPEED        = MAX_SPEED_DEF,
    parameter int         RAMP_TENTHS      = 50,
    parameter logic [7:0] LFSR_SEED        = 8'hA5
) (
    input  logic                      clk,
    input  logic                      resetN,
    input  logic                      startOfFrame,
    input  logic                      oneTensSec,
    input  logic                      startOfLevel,
    input  logic                      endLevel,
    input  logic [3:0]                levelNumber,
    input  logic [NUM_TILES-1:0]      tileDoneVector,
    output logic [NUM_TILES-1:0]      spawnPulseVector,
    output logic [NUM_TILES-1:0][7:0] spawnSeed,
    output logic [NUM_TILES-1:0]      activeVector,
    output logic [31:0]               levelSpeed,
    output logic                      levelDone
);

    localparam int RRW = (NUM_TILES > 1) ? $clog2(NUM_TILES) : 1;

    sched_state_t                state_q, state_d;
    logic [NUM_TILES-1:0]        active_q, active_d;
    logic [NUM_TILES-1:0][7:0]   seed_q, seed_d;
    logic [31:0]                 speed_q, speed_d;
    logic [15:0]                 gap_q, gap_d;
    logic [15:0]                 ramp_q, ramp_d;
    logic [RRW-1:0]              rr_q, rr_d;
    logic                        pending_q, pending_d;

    logic [7:0]                  lfsr;
    logic [NUM_TILES-1:0]        active_rel;
    logic                        found;
    logic [RRW-1:0]              lane;
    logic [RRW-1:0]              scan_idx;
    logic                        level_entry;
    logic [31:0]                 entry_speed;
    logic [NUM_TILES-1:0]        spawn_vec;
    logic                        level_done;

    tile_lfsr8 #(
        .SEED (LFSR_SEED)
    ) u_lfsr (
        .clk   (clk),
        .rst_n (resetN),
        .en    (startOfFrame),
        .lfsr  (lfsr)
    );

    // Releases apply before the spawn search so a lane freed this cycle is already eligible.
    always_comb begin
        active_rel = active_q;
        if (state_q != IDLE) begin
            active_rel = active_q & ~tileDoneVector;
        end
    end

    // Round-robin search for the first free lane starting at rr_q.
    always_comb begin
        found    = 1'b0;
        lane     = '0;
        scan_idx = '0;
        for (int k = 0; k < NUM_TILES; k++) begin
            scan_idx = RRW'((int'(rr_q) + k) % NUM_TILES);
            if (!found && !active_rel[scan_idx]) begin
                found = 1'b1;
                lane  = scan_idx;
            end
        end
    end

    // Level start/restart, gap and ramp timing, spawn issue and drain completion.
    always_comb begin
        state_d     = state_q;
        active_d    = active_rel;
        seed_d      = seed_q;
        speed_d     = speed_q;
        gap_d       = gap_q;
        ramp_d      = ramp_q;
        rr_d        = rr_q;
        pending_d   = pending_q;
        spawn_vec   = '0;
        level_done  = 1'b0;
        entry_speed = sat_add(32'(BASE_SPEED), 32'(levelNumber) * 32'(SPEED_STEP), 32'(MAX_SPEED));
        // endLevel outranks startOfLevel, and a draining level ignores new starts.
        level_entry = startOfLevel && !endLevel && (state_q != DRAIN);

        if (level_entry) begin
            state_d   = RUN;
            speed_d   = entry_speed;
            gap_d     = '0;
            ramp_d    = '0;
            pending_d = 1'b1;
            rr_d      = '0;
        end else begin
            case (state_q)
                RUN: begin
                    if (endLevel) begin
                        state_d   = DRAIN;
                        pending_d = 1'b0;
                    end else begin
                        if (oneTensSec) begin
                            if (gap_q != '0) begin
                                gap_d = gap_q - 16'd1;
                                if (gap_q == 16'd1) begin
                                    pending_d = 1'b1;
                                end
                            end
                            if (ramp_q == 16'(RAMP_TENTHS - 1)) begin
                                ramp_d  = '0;
                                speed_d = sat_add(speed_q, 32'(SPEED_STEP), 32'(MAX_SPEED));
                            end else begin
                                ramp_d = ramp_q + 16'd1;
                            end
                        end
                        // Uses pending_q: a pending bit raised by this cycle's tick waits for the next frame.
                        if (startOfFrame && pending_q && found) begin
                            spawn_vec[lane] = 1'b1;
                            seed_d[lane]    = lfsr;
                            active_d[lane]  = 1'b1;
                            rr_d            = RRW'((int'(lane) + 1) % NUM_TILES);
                            pending_d       = 1'b0;
                            gap_d           = 16'(SPAWN_GAP_TENTHS);
                        end
                    end
                end
                DRAIN: begin
                    if (active_q == '0) begin
                        state_d    = IDLE;
                        level_done = 1'b1;
                        speed_d    = '0;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    // Scheduler state registers; reset aborts any level in progress.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state_q   <= IDLE;
            active_q  <= '0;
            seed_q    <= '0;
            speed_q   <= '0;
            gap_q     <= '0;
            ramp_q    <= '0;
            rr_q      <= '0;
            pending_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            active_q  <= active_d;
            seed_q    <= seed_d;
            speed_q   <= speed_d;
            gap_q     <= gap_d;
            ramp_q    <= ramp_d;
            rr_q      <= rr_d;
            pending_q <= pending_d;
        end
    end

    assign spawnPulseVector = spawn_vec;
    assign spawnSeed        = seed_d;   // the fresh seed shows in the spawn cycle, then the held one
    assign activeVector     = active_q;
    assign levelSpeed       = speed_q;
    assign levelDone        = level_done;

endmodule

// File: tb/tb_tile_spawn_scheduler.sv
// Directed bench for tile_spawn_scheduler with a spawn scoreboard and an independent LFSR model.
// Latency: n/a.
// Backpressure: n/a.
module tb_tile_spawn_scheduler;

    logic            clk = 1'b0;
    logic            resetN = 1'b0;
    logic            startOfFrame = 1'b0;
    logic            oneTensSec = 1'b0;
    logic            startOfLevel = 1'b0;
    logic            endLevel = 1'b0;
    logic [3:0]      levelNumber = 4'd0;
    logic [3:0]      tileDoneVector = 4'd0;
    logic [3:0]      spawnPulseVector;
    logic [3:0][7:0] spawnSeed;
    logic [3:0]      activeVector;
    logic [31:0]     levelSpeed;
    logic            levelDone;

    int              n_cmp = 0;
    int              n_bad = 0;
    logic [7:0]      mlfsr = 8'hA5;
    logic [3:0]      q_pulse[$];
    logic [7:0]      q_seed[$];

    tile_spawn_scheduler dut (
        .clk              (clk),
        .resetN           (resetN),
        .startOfFrame     (startOfFrame),
        .oneTensSec       (oneTensSec),
        .startOfLevel     (startOfLevel),
        .endLevel         (endLevel),
        .levelNumber      (levelNumber),
        .tileDoneVector   (tileDoneVector),
        .spawnPulseVector (spawnPulseVector),
        .spawnSeed        (spawnSeed),
        .activeVector     (activeVector),
        .levelSpeed       (levelSpeed),
        .levelDone        (levelDone)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    // Reference LFSR: x^8+x^6+x^5+x^4+1, shifting left.
    function automatic logic [7:0] lfsr_next(input logic [7:0] v);
        logic fb;
        fb = v[7] ^ v[5] ^ v[4] ^ v[3];
        return {v[6:0], fb};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drive one cycle's inputs and move to mid-cycle, where outputs are sampled.
    task automatic cycle_in(input logic sof, input logic tick, input logic sol,
                            input logic el, input logic [3:0] done);
        startOfFrame   = sof;
        oneTensSec     = tick;
        startOfLevel   = sol;
        endLevel       = el;
        tileDoneVector = done;
        @(negedge clk);
    endtask

    // Let the cycle commit, track the frame-driven LFSR, clear the pulses.
    task automatic finish_cyc();
        @(posedge clk);
        if (startOfFrame) mlfsr = lfsr_next(mlfsr);
        #1;
        startOfFrame   = 1'b0;
        oneTensSec     = 1'b0;
        startOfLevel   = 1'b0;
        endLevel       = 1'b0;
        tileDoneVector = 4'd0;
    endtask

    task automatic ticks(input int n);
        repeat (n) begin
            cycle_in(1'b0, 1'b1, 1'b0, 1'b0, 4'd0);
            finish_cyc();
        end
    endtask

    // A frame cycle: expected pulse and seed are queued when driven and popped when sampled.
    task automatic frame(input logic [3:0] exp_pulse, input logic tick,
                         input logic [3:0] done, input string tag);
        logic [3:0] ep;
        logic [7:0] es;
        q_pulse.push_back(exp_pulse);
        q_seed.push_back(mlfsr);
        cycle_in(1'b1, tick, 1'b0, 1'b0, done);
        ep = q_pulse.pop_front();
        es = q_seed.pop_front();
        chk({tag, "_pulse"}, 32'(spawnPulseVector), 32'(ep));
        for (int i = 0; i < 4; i++) begin
            if (ep[i]) chk({tag, "_seed"}, 32'(spawnSeed[i]), 32'(es));
        end
        finish_cyc();
    endtask

    initial begin
        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_pulse", 32'(spawnPulseVector), 32'd0);
        chk("rst_active", 32'(activeVector), 32'd0);
        chk("rst_seed", 32'(spawnSeed), 32'd0);
        chk("rst_speed", levelSpeed, 32'd0);
        chk("rst_done", 32'(levelDone), 32'd0);
        @(posedge clk);
        #1;
        resetN = 1'b1;
        mlfsr  = 8'hA5;

        // Level 2 start, first spawn on lane 0 with the reset seed
        levelNumber = 4'd2;
        cycle_in(1'b0, 1'b0, 1'b1, 1'b0, 4'd0);
        finish_cyc();
        cycle_in(1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
        chk("l2_speed", levelSpeed, 32'd80);
        chk("l2_active_pre", 32'(activeVector), 32'd0);
        finish_cyc();
        frame(4'b0001, 1'b0, 4'd0, "spawn0");
        cycle_in(1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
        chk("active_0001", 32'(activeVector), 32'b0001);
        finish_cyc();

        // Gap not yet elapsed: no spawn after 14 ticks
        ticks(14);
        frame(4'b0000, 1'b0, 4'd0, "gap_early");
        ticks(1);
        frame(4'b0010, 1'b0, 4'd0, "spawn1");
        cycle_in(1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
        chk("seed0_held", 32'(spawnSeed[0]), 32'hA5);
        finish_cyc();
        ticks(15);
        frame(4'b0100, 1'b0, 4'd0, "spawn2");
        ticks(15);
        frame(4'b1000, 1'b0, 4'd0, "spawn3");
        ticks(15);
        frame(4'b0000, 1'b0, 4'd0, "all_busy");
        cycle_in(1'b0, 1'b0, 1'b0, 1'b0, 4'b0100);
        chk("speed_ramp1", levelSpeed, 32'd88);
        finish_cyc();
        frame(4'b0100, 1'b0, 4'd0, "respawn2");

        // Release and spawn in the same frame: freed lane 0 is taken
        ticks(15);
        frame(4'b0001, 1'b0, 4'b0001, "same_frame");
        cycle_in(1'b0, 1'b0, 1'b0, 1'b0, 4'b0010);
        chk("active_full", 32'(activeVector), 32'b1111);
        finish_cyc();

        // Tick and frame together: pending raised now only acts next frame
        ticks(14);
        frame(4'b0000, 1'b1, 4'd0, "tick_sof");
        frame(4'b0010, 1'b0, 4'd0, "after_tick_sof");

        // Drain with lanes 0 and 1 live
        cycle_in(1'b0, 1'b0, 1'b0, 1'b0, 4'b1100);
        finish_cyc();
        cycle_in(1'b0, 1'b0, 1'b0, 1'b1, 4'd0);
        chk("drain_active", 32'(activeVector), 32'b0011);
        finish_cyc();
        ticks(15);
        frame(4'b0000, 1'b0, 4'd0, "drain_nospawn");
        cycle_in(1'b0, 1'b0, 1'b0, 1'b0, 4'b0001);
        chk("drain_speed_frozen", levelSpeed, 32'd88);
        chk("drain_done0", 32'(levelDone), 32'd0);
        finish_cyc();
        cycle_in(1'b0, 1'b0, 1'b1, 1'b0, 4'b0010);
        chk("drain_active_0010", 32'(activeVector), 32'b0010);
        chk("drain_done1", 32'(levelDone), 32'd0);
        finish_cyc();
        cycle_in(1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
        chk("drain_done_pulse", 32'(levelDone), 32'd1);
        finish_cyc();
        cycle_in(1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
        chk("drain_done_once", 32'(levelDone), 32'd0);
        chk("idle_speed", levelSpeed, 32'd0);
        finish_cyc();
        frame(4'b0000, 1'b0, 4'd0, "idle_nospawn");

        // startOfLevel with endLevel in IDLE stays idle
        levelNumber = 4'd5;
        cycle_in(1'b0, 1'b0, 1'b1, 1'b1, 4'd0);
        finish_cyc();
        cycle_in(1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
        chk("prio_speed", levelSpeed, 32'd0);
        finish_cyc();
        frame(4'b0000, 1'b0, 4'd0, "prio_nospawn");

        // Level 15 ramp to saturation
        levelNumber = 4'd15;
        cycle_in(1'b0, 1'b0, 1'b1, 1'b0, 4'd0);
        finish_cyc();
        cycle_in(1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
        chk("l15_speed", levelSpeed, 32'd184);
        finish_cyc();
        frame(4'b0001, 1'b0, 4'd0, "l15_spawn0");
        for (int k = 1; k <= 13; k++) begin
            ticks(50);
            cycle_in(1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
            chk("ramp_step", levelSpeed, (184 + 8 * k > 256) ? 32'd256 : 32'(184 + 8 * k));
            finish_cyc();
        end

        // Restart in RUN: new speed, lanes untouched, rr back at 0
        levelNumber = 4'd0;
        cycle_in(1'b0, 1'b0, 1'b1, 1'b0, 4'd0);
        finish_cyc();
        cycle_in(1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
        chk("restart_speed", levelSpeed, 32'd64);
        chk("restart_active", 32'(activeVector), 32'b0001);
        finish_cyc();
        frame(4'b0010, 1'b0, 4'd0, "restart_spawn");

        // Asynchronous reset mid-level
        #2;
        resetN = 1'b0;
        #1;
        chk("arst_pulse", 32'(spawnPulseVector), 32'd0);
        chk("arst_active", 32'(activeVector), 32'd0);
        chk("arst_seed", 32'(spawnSeed), 32'd0);
        chk("arst_speed", levelSpeed, 32'd0);
        chk("arst_done", 32'(levelDone), 32'd0);
        @(posedge clk);
        #1;
        resetN = 1'b1;
        mlfsr  = 8'hA5;
        levelNumber = 4'd2;
        cycle_in(1'b0, 1'b0, 1'b1, 1'b0, 4'd0);
        finish_cyc();
        frame(4'b0001, 1'b0, 4'd0, "post_rst_spawn");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
